// File: rtl/pipe_register_pkg.sv
// Shared definitions for the pipe_register block: default geometry and the
// helper that derives the occupancy-count width from the stage count.
package pipe_register_pkg;

  localparam int DEF_WIDTH = 12;
  localparam int DEF_DEPTH = 3;

  // Bits needed to hold any value 0..depth inclusive (at least one bit).
  function automatic int calc_cnt_w(input int depth);
    if (depth < 1) begin
      return 1;
    end
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_register_stage.sv
// One slot of the register chain: a WIDTH-bit data register plus its valid
// bit. The stage either advances (takes the upstream word/bubble) or holds.
module pipe_stage
  import pipe_register_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             adv,
  input  logic [WIDTH-1:0] d,
  input  logic             vin,
  output logic [WIDTH-1:0] q,
  output logic             vout
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  // Valid bit: cleared by reset or flush, otherwise follows upstream on advance.
  // NOTE: sequential state uses non-blocking (<=) so every stage samples the
  // pre-edge value of its neighbour; blocking here would shoot words through.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (adv) begin
      r_valid <= vin;
    end
  end

  // Data register: loads only a real word on advance; bubbles and flushes
  // leave the previously held value in place.
  // NOTE: the data register is reset even though valid alone would suffice,
  // so data_out reads as zero out of reset rather than an unknown value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
    end else if (adv && vin && !flush) begin
      r_data <= d;
    end
  end

  assign q    = r_data;
  assign vout = r_valid;

endmodule

// File: rtl/pipe_register.sv
// Parametrised valid/ready register chain with bubble collapsing, synchronous
// flush and a registered occupancy count. The ready chain is purely
// combinational from out_ready back to in_ready.
module pipe_register
  import pipe_register_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  // Derived from DEPTH; leave at its default.
  parameter int CNT_W = calc_cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] data_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count
);

  logic [DEPTH-1:0] w_v;
  logic [DEPTH-1:0] w_adv;
  logic [DEPTH-1:0] w_vin;
  logic [WIDTH-1:0] w_q [DEPTH];
  logic [WIDTH-1:0] w_d [DEPTH];
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_in_hs;
  logic             w_out_hs;
  logic [CNT_W-1:0] r_count;

  // Advance chain: stage i may move when downstream drains or any stage at or
  // after i is empty. Written as a per-stage reduction so the chain does not
  // feed back on itself inside one vector.
  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    logic tail_full;
    w_adv     = '0;
    tail_full = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      tail_full = 1'b1;
      for (int j = i; j < DEPTH; j++) begin
        tail_full = tail_full & w_v[j];
      end
      w_adv[i] = out_ready | ~tail_full;
    end
  end

  assign w_in_ready  = w_adv[0] & ~flush;
  assign w_out_valid = w_v[DEPTH-1] & ~flush;
  assign w_in_hs     = in_valid & w_in_ready;
  assign w_out_hs    = w_out_valid & out_ready;

  // Stage chain: stage 0 takes the input handshake, later stages take their
  // upstream neighbour.
  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign w_d[g]   = data_in;
      assign w_vin[g] = w_in_hs;
    end else begin : g_body
      assign w_d[g]   = w_q[g-1];
      assign w_vin[g] = w_v[g-1];
    end

    pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .adv   (w_adv[g]),
      .d     (w_d[g]),
      .vin   (w_vin[g]),
      .q     (w_q[g]),
      .vout  (w_v[g])
    );
  end

  // Occupancy count: +1 per input handshake, -1 per output handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (flush) begin
      r_count <= '0;
    end else begin
      case ({w_in_hs, w_out_hs})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign data_out  = w_q[DEPTH-1];
  assign count     = r_count;

endmodule

// File: doc/pipe_register.md
Name: pipe_register

Overview:
- Parametrised successor to the team's fixed-width data register: a chain of DEPTH registers, each WIDTH bits wide, with per-stage valid bits.
- Uses a valid/ready handshake and bubble collapsing: empty stages are filled even while the output is stalled.
- Adds a synchronous flush and an occupancy count.
- Sits between datapath blocks that need registered, back-pressurable transfer (e.g. between a multiplier and an accumulator).

Parameters:
- WIDTH, 12: data width in bits.
- DEPTH, 3: number of register stages; legal range is DEPTH >= 1.
- CNT_W, $clog2(DEPTH+1): width of the occupancy count. Derived; not to be overridden.

Ports:
- clk  in  1  Single clock. All state changes on the rising edge.
- rst  in  1  Asynchronous, active-high reset.
- flush  in  1  Synchronous clear of all stages. Has priority over everything except rst.
- data_in  in  WIDTH  Input word.
- in_valid  in  1  data_in is valid.
- in_ready  out  1  Stage 0 can accept this cycle.
- data_out  out  WIDTH  Word held in the last stage (DEPTH-1).
- out_valid  out  1  data_out is valid.
- out_ready  in  1  Downstream accepts data_out this cycle.
- count  out  CNT_W  Number of valid stages, registered.

Behaviour:
- Reset: while rst=1, and asynchronously on its assertion, all valid bits=0, all stage data=0, count=0. Therefore out_valid=0, data_out=0 and in_ready=1 (when flush=0).
- Per stage i, advance signal:
  - adv[DEPTH-1] = out_ready | ~v[DEPTH-1]
  - adv[i] = adv[i+1] | ~v[i], for i < DEPTH-1
- The advance/ready chain is combinational and runs from out_ready back to in_ready; there is no registered ready path.
- in_ready = adv[0] & ~flush.
- out_valid = v[DEPTH-1] & ~flush.
- Stage update on a rising clock edge when adv[i]=1:
  - stage 0 loads data_in with v[0] <= in_valid & in_ready.
  - stage i>0 loads stage i-1 with v[i] <= v[i-1].
  - When adv[i]=0 the stage holds both data and valid.
  - Data registers load only on adv[i]; a bubble never overwrites held data.
- Latency: a word accepted at edge k, with no stall, is visible on data_out with out_valid=1 after edge k+DEPTH-1. That is DEPTH cycles from the input handshake. DEPTH=1 gives one-cycle latency.
- Throughput: one word per cycle when out_ready is held at 1.
- Stall (out_ready=0 with the last stage valid):
  - Upstream stages keep advancing into empty stages until the chain is full.
  - in_ready falls only when all DEPTH stages are valid.
- Full plus simultaneous output: when all stages are valid and out_ready=1, in_ready=1 in the same cycle. Input and output transfer together and count is unchanged.
- Ordering: words leave in acceptance order. None are dropped or duplicated.
- Flush=1 at an edge:
  - All valid bits clear and count becomes 0.
  - Stage data is held, not zeroed.
  - No input is accepted; no output handshake occurs (out_valid is masked during the flush cycle).
- count: next value = count + (input handshake) - (output handshake). Zero on flush/reset. Always in the range 0..DEPTH.
- Reset asserted mid-transfer: all in-flight words are lost and the block is empty on release.
- data_in is ignored whenever in_valid=0.

Decomposition:
- Shared package: function to compute CNT_W (clog2).
- Sub-module pipe_stage:
  - Holds one WIDTH register plus its valid bit.
  - Inputs: adv, d, vin. Outputs: q, vout.
  - Instantiated DEPTH times by a generate loop. The top level holds the ready chain and the counter.

Test Plan (WIDTH=12, DEPTH=3 unless noted):
1. Reset: assert rst with in_valid=1 and data_in=12'hABC -> out_valid=0, data_out=0, count=0, in_ready=1. After release with no input, outputs are unchanged.
2. Streaming: out_ready=1, send 12'h001..12'h00A on consecutive cycles -> 12'h001 appears 3 cycles after its handshake, one word per cycle, in order. count settles at 3.
3. Stall and fill: out_ready=0, send 12'h111, 12'h222, 12'h333, 12'h444 -> first three accepted and count=3. in_ready=0 while 12'h444 waits. Set out_ready=1 -> 12'h111 transfers and 12'h444 is accepted in the same cycle; count stays 3.
4. Bubble collapse: send 12'h0F0, one idle cycle, then 12'h00F, with out_ready=0 -> both reach stages 2 and 1 and count=2. Releasing out_ready drains 12'h0F0 then 12'h00F back-to-back.
5. Flush: with count=3, pulse flush for one cycle while in_valid=1 and out_ready=1 -> in_ready=0 and out_valid=0 that cycle. Afterwards count=0 and no stale word ever appears.
6. DEPTH=1: out_ready=0, send 12'hFFF then 12'h123 -> in_ready=0 while full. Set out_ready=1 -> 12'hFFF transfers and 12'h123 loads in the same edge; one-cycle latency confirmed.
